cla_addsub_unit: RTL and testbench

- Parametrised successor to the 16-bit CLA datapath.
- Adds an internal controller FSM, ready/valid handshakes on a shared operand bus, add/subtract mode, accumulate mode and a signed-overflow flag.
- Uses a two-level carry-lookahead: group G/P per BLK bits, then lookahead across groups, with no ripple between groups.
- Sits between an operand source on the shared data bus and a result consumer.

---
 rtl/cla_pkg.sv | 19 +
 rtl/cla_group.sv | 44 ++++
 rtl/cla_addsub_unit.sv | 174 +++++++++++++++++
 tb/tb_cla_addsub_unit.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the carry-lookahead add/subtract unit.
package cla_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GET_B = 2'd1,
    CALC  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // The lookahead tree needs whole groups: N must be a non-zero multiple of BLK.
  function automatic bit cla_cfg_ok(input int unsigned n, input int unsigned blk);
    return (blk != 0) && (n != 0) && ((n % blk) == 0);
  endfunction

endpackage

// File: rtl/cla_group.sv
// One BLK-bit lookahead group: local sum from the supplied carry-in,
// plus group generate/propagate for the top-level lookahead.
module cla_group
  import cla_pkg::*;
#(
  parameter int unsigned BLK = 4
) (
  input  logic [BLK-1:0] a_i,
  input  logic [BLK-1:0] b_i,
  input  logic           cin_i,
  output logic [BLK-1:0] sum_o,
  output logic           g_o,
  output logic           p_o
);

  logic [BLK-1:0] gen;
  logic [BLK-1:0] prop;
  logic           c;
  logic           gacc;

  assign gen  = a_i & b_i;
  assign prop = a_i ^ b_i;

  // Group G/P depend only on a and b, so they never wait on cin_i.
  always_comb begin
    gacc = 1'b0;
    for (int unsigned i = 0; i < BLK; i++) begin
      gacc = gen[i] | (prop[i] & gacc);
    end
    g_o = gacc;
    p_o = &prop;
  end

  // Bit sums inside the group once the group carry-in is known.
  always_comb begin
    c     = cin_i;
    sum_o = '0;
    for (int unsigned i = 0; i < BLK; i++) begin
      sum_o[i] = prop[i] ^ c;
      c        = gen[i] | (prop[i] & c);
    end
  end

endmodule

// File: rtl/cla_addsub_unit.sv
// Handshaked add/subtract/accumulate unit built on a two-level
// carry-lookahead adder. Operands arrive on a shared bus (A then B),
// or B alone when the accumulator stands in for A.
module cla_addsub_unit
  import cla_pkg::*;
#(
  parameter int unsigned N   = 16,
  parameter int unsigned BLK = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] data_in,
  input  logic         carry_in,
  input  logic         mode,
  input  logic         acc_en,
  input  logic         clear,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N:0]   data_out,
  output logic         overflow,
  output logic         busy
);

  localparam int unsigned NG = N / BLK;

  if (!cla_cfg_ok(N, BLK)) begin : g_bad_cfg
    $error("cla_addsub_unit: N must be a non-zero multiple of BLK");
  end

  state_e         state_q, state_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic           mode_q, mode_d;
  logic           cin_q, cin_d;
  logic [N-1:0]   acc_q, acc_d;
  logic [N:0]     res_q, res_d;
  logic           ovf_q, ovf_d;

  logic [N-1:0]   bx;
  logic           c0;
  logic [NG-1:0]  grp_g;
  logic [NG-1:0]  grp_p;
  logic [NG:0]    gc;
  logic [N-1:0]   sum;
  logic           cout;
  logic           c_msb;

  // Subtraction is A + ~B + 1; a set carry_in then turns the +1 into +0 (A-B-1).
  assign bx = (mode_q == MODE_SUB) ? ~b_q : b_q;
  assign c0 = cin_q ^ mode_q;

  for (genvar g = 0; g < NG; g++) begin : g_grp
    cla_group #(.BLK(BLK)) u_grp (
      .a_i   (a_q[g*BLK +: BLK]),
      .b_i   (bx[g*BLK +: BLK]),
      .cin_i (gc[g]),
      .sum_o (sum[g*BLK +: BLK]),
      .g_o   (grp_g[g]),
      .p_o   (grp_p[g])
    );
  end

  // Each group carry is a flat sum of products over group G/P and c0,
  // so no group waits on a neighbour's carry-out.
  always_comb begin
    logic cy;
    logic pp;
    gc    = '0;
    gc[0] = c0;
    for (int unsigned k = 1; k <= NG; k++) begin
      cy = 1'b0;
      for (int unsigned j = 0; j < k; j++) begin
        pp = grp_g[j];
        for (int unsigned m = j + 1; m < k; m++) begin
          pp = pp & grp_p[m];
        end
        cy = cy | pp;
      end
      pp = c0;
      for (int unsigned m = 0; m < k; m++) begin
        pp = pp & grp_p[m];
      end
      gc[k] = cy | pp;
    end
  end

  assign cout  = gc[NG];
  // Carry into the MSB recovered from the MSB sum bit and its operands.
  assign c_msb = sum[N-1] ^ a_q[N-1] ^ bx[N-1];

  // State and datapath registers; reset discards any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= MODE_ADD;
      cin_q   <= 1'b0;
      acc_q   <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      cin_q   <= cin_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
    end
  end

  // Controller: operand capture, one compute cycle, hold result until taken.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    cin_d   = cin_q;
    acc_d   = acc_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (acc_en) begin
            a_d     = clear ? '0 : acc_q;
            b_d     = data_in;
            mode_d  = mode;
            cin_d   = carry_in;
            state_d = CALC;
          end else begin
            a_d     = data_in;
            state_d = GET_B;
          end
        end
      end
      GET_B: begin
        if (in_valid) begin
          b_d     = data_in;
          mode_d  = mode;
          cin_d   = carry_in;
          state_d = CALC;
        end
      end
      CALC: begin
        res_d   = {cout, sum};
        ovf_d   = c_msb ^ cout;
        acc_d   = sum;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Clear overrides any accumulator write, in every state.
    if (clear) begin
      acc_d = '0;
    end
  end

  assign in_ready  = (state_q == IDLE) || (state_q == GET_B);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign data_out  = res_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_cla_addsub_unit.sv
// Directed and random checks of cla_addsub_unit at N=16/BLK=4 and N=32/BLK=8.
module tb_cla_addsub_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        in_valid, in_ready, carry_in, mode, acc_en, clear;
  logic        out_valid, out_ready, overflow, busy;
  logic [15:0] data_in;
  logic [16:0] data_out;

  logic        in_valid_w, in_ready_w, carry_in_w, mode_w, acc_en_w, clear_w;
  logic        out_valid_w, out_ready_w, overflow_w, busy_w;
  logic [31:0] data_in_w;
  logic [32:0] data_out_w;

  cla_addsub_unit #(.N(16), .BLK(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .carry_in(carry_in), .mode(mode), .acc_en(acc_en),
    .clear(clear), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .overflow(overflow), .busy(busy)
  );

  cla_addsub_unit #(.N(32), .BLK(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_w), .in_ready(in_ready_w),
    .data_in(data_in_w), .carry_in(carry_in_w), .mode(mode_w), .acc_en(acc_en_w),
    .clear(clear_w), .out_valid(out_valid_w), .out_ready(out_ready_w),
    .data_out(data_out_w), .overflow(overflow_w), .busy(busy_w)
  );

  int tests_run = 0;
  int fails     = 0;

  logic [17:0] sb16[$];   // {overflow, carry_out, sum}
  logic [33:0] sb32[$];
  logic [15:0] acc16;
  logic [31:0] acc32;

  function automatic logic [17:0] model16(input logic [15:0] a, input logic [15:0] b,
                                          input logic md, input logic ci);
    logic [15:0] bxv;
    logic [16:0] full;
    logic        ov;
    bxv  = md ? ~b : b;
    full = {1'b0, a} + {1'b0, bxv} + {16'd0, ci ^ md};
    ov   = (a[15] == bxv[15]) && (full[15] != a[15]);
    return {ov, full};
  endfunction

  function automatic logic [33:0] model32(input logic [31:0] a, input logic [31:0] b,
                                          input logic md, input logic ci);
    logic [31:0] bxv;
    logic [32:0] full;
    logic        ov;
    bxv  = md ? ~b : b;
    full = {1'b0, a} + {1'b0, bxv} + {32'd0, ci ^ md};
    ov   = (a[31] == bxv[31]) && (full[31] != a[31]);
    return {ov, full};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive16(input logic [15:0] d, input logic acc, input logic md,
                         input logic ci, input logic clr);
    int n = 0;
    in_valid = 1'b1; data_in = d; acc_en = acc; mode = md; carry_in = ci; clear = clr;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("in_ready_timeout16", 64'(n >= 50), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; acc_en = 1'b0; mode = 1'b0; carry_in = 1'b0; clear = 1'b0;
  endtask

  task automatic issue16(input logic [15:0] a, input logic [15:0] b,
                         input logic md, input logic ci);
    logic [17:0] e;
    drive16(a, 1'b0, 1'b0, 1'b0, 1'b0);
    drive16(b, 1'b0, md, ci, 1'b0);
    e = model16(a, b, md, ci);
    sb16.push_back(e);
    acc16 = e[15:0];
  endtask

  task automatic issue_acc16(input logic [15:0] b, input logic md, input logic ci,
                             input logic clr);
    logic [17:0] e;
    logic [15:0] av;
    av = clr ? 16'd0 : acc16;
    drive16(b, 1'b1, md, ci, clr);
    e = model16(av, b, md, ci);
    sb16.push_back(e);
    acc16 = e[15:0];
  endtask

  task automatic collect16(input string tag);
    int n = 0;
    logic [17:0] e;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_timeout"}, 64'(n >= 20), 64'd0);
    e = (sb16.size() > 0) ? sb16.pop_front() : 18'h3FFFF;
    chk({tag, "_data"}, 64'(data_out), 64'(e[16:0]));
    chk({tag, "_ovf"},  64'(overflow), 64'(e[17]));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic drive32(input logic [31:0] d, input logic acc, input logic md,
                         input logic ci, input logic clr);
    int n = 0;
    in_valid_w = 1'b1; data_in_w = d; acc_en_w = acc; mode_w = md; carry_in_w = ci;
    clear_w = clr;
    while (!in_ready_w && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("in_ready_timeout32", 64'(n >= 50), 64'd0);
    @(posedge clk); #1;
    in_valid_w = 1'b0; acc_en_w = 1'b0; mode_w = 1'b0; carry_in_w = 1'b0; clear_w = 1'b0;
  endtask

  task automatic collect32();
    int n = 0;
    logic [33:0] e;
    while (!out_valid_w && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("rand32_timeout", 64'(n >= 20), 64'd0);
    e = (sb32.size() > 0) ? sb32.pop_front() : 34'h3_FFFF_FFFF;
    chk("rand32_data", 64'(data_out_w), 64'(e[32:0]));
    chk("rand32_ovf",  64'(overflow_w), 64'(e[33]));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [17:0] e;
    rst_n = 1'b0;
    in_valid = 1'b0; data_in = '0; carry_in = 1'b0; mode = 1'b0; acc_en = 1'b0;
    clear = 1'b0; out_ready = 1'b0;
    in_valid_w = 1'b0; data_in_w = '0; carry_in_w = 1'b0; mode_w = 1'b0; acc_en_w = 1'b0;
    clear_w = 1'b0; out_ready_w = 1'b0;
    acc16 = '0; acc32 = '0;

    // Reset state
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_data_out",  64'(data_out),  64'd0);
    chk("rst_overflow",  64'(overflow),  64'd0);
    chk("rst_data_out32", 64'(data_out_w), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic add with latency and busy window
    drive16(16'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lat_busy_getb", 64'(busy), 64'd1);
    drive16(16'h4321, 1'b0, 1'b0, 1'b0, 1'b0);
    e = model16(16'h1234, 16'h4321, 1'b0, 1'b0);
    sb16.push_back(e);
    acc16 = e[15:0];
    chk("lat_calc_out_valid", 64'(out_valid), 64'd0);
    chk("lat_calc_in_ready",  64'(in_ready),  64'd0);
    chk("lat_calc_busy",      64'(busy),      64'd1);
    @(posedge clk); #1;
    chk("lat_done_out_valid", 64'(out_valid), 64'd1);
    chk("lat_done_busy",      64'(busy),      64'd1);
    chk("add_expect", 64'(e[16:0]), 64'h05555);
    collect16("add_1234_4321");
    chk("lat_exit_busy",     64'(busy),     64'd0);
    chk("lat_exit_in_ready", 64'(in_ready), 64'd1);

    // Subtract, borrow and no-borrow
    issue16(16'h0005, 16'h0007, 1'b1, 1'b0); collect16("sub_5_7");
    issue16(16'h0007, 16'h0005, 1'b1, 1'b0); collect16("sub_7_5");
    issue16(16'h0007, 16'h0005, 1'b1, 1'b1); collect16("sub_7_5_cin");
    issue16(16'h1000, 16'h0001, 1'b0, 1'b1); collect16("add_cin");

    // Overflow boundaries
    issue16(16'h7FFF, 16'h0001, 1'b0, 1'b0); collect16("add_ovf");
    issue16(16'hFFFF, 16'h0001, 1'b0, 1'b0); collect16("add_wrap");
    issue16(16'h8000, 16'h0001, 1'b1, 1'b0); collect16("sub_ovf");

    // Accumulate with clear in IDLE, then clear on the handshake
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    acc16 = '0;
    issue_acc16(16'h0010, 1'b0, 1'b0, 1'b0); collect16("acc_1");
    issue_acc16(16'h0010, 1'b0, 1'b0, 1'b0); collect16("acc_2");
    issue_acc16(16'h0010, 1'b0, 1'b0, 1'b0); collect16("acc_3");
    issue_acc16(16'h0010, 1'b0, 1'b0, 1'b1); collect16("acc_clr_hs");
    issue_acc16(16'h0003, 1'b1, 1'b0, 1'b0); collect16("acc_sub");

    // Back-pressure: result held while the consumer stalls
    issue16(16'h7FFF, 16'h7FFF, 1'b0, 1'b0);
    for (int i = 0; i < 20 && !out_valid; i++) begin
      @(posedge clk); #1;
    end
    e = (sb16.size() > 0) ? sb16[0] : 18'h3FFFF;
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      data_in  = 16'($urandom);
      mode     = ~mode;
      acc_en   = ~acc_en;
      @(posedge clk); #1;
      chk("hold_out_valid", 64'(out_valid), 64'd1);
      chk("hold_data",      64'(data_out),  64'(e[16:0]));
      chk("hold_ovf",       64'(overflow),  64'(e[17]));
      chk("hold_in_ready",  64'(in_ready),  64'd0);
    end
    in_valid = 1'b0; mode = 1'b0; acc_en = 1'b0;
    collect16("hold_release");
    chk("hold_in_ready_after", 64'(in_ready), 64'd1);

    // Asynchronous reset in CALC
    drive16(16'h1111, 1'b0, 1'b0, 1'b0, 1'b0);
    drive16(16'h2222, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rstcalc_in_calc", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("rstcalc_out_valid", 64'(out_valid), 64'd0);
    chk("rstcalc_busy",      64'(busy),      64'd0);
    chk("rstcalc_in_ready",  64'(in_ready),  64'd1);
    chk("rstcalc_data_out",  64'(data_out),  64'd0);
    sb16.delete();
    acc16 = '0;
    acc32 = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue_acc16(16'h0010, 1'b0, 1'b0, 1'b0); collect16("rstcalc_acc_zero");

    // Wide configuration against the model
    out_ready_w = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] a, b, av;
      logic        md, ci, ac, cl;
      logic [33:0] ew;
      a  = $urandom;
      b  = $urandom;
      md = 1'($urandom);
      ci = 1'($urandom);
      ac = ($urandom_range(0, 3) == 0);
      cl = ($urandom_range(0, 15) == 0);
      if (i < 4) begin
        a = 32'h7FFF_FFFF; b = 32'h0000_0001; md = i[0]; ci = i[1]; ac = 1'b0;
      end
      if (ac) begin
        av = cl ? 32'd0 : acc32;
        drive32(b, 1'b1, md, ci, cl);
      end else begin
        av = a;
        drive32(a, 1'b0, 1'b0, 1'b0, 1'b0);
        drive32(b, 1'b0, md, ci, 1'b0);
      end
      ew = model32(av, b, md, ci);
      sb32.push_back(ew);
      acc32 = ew[31:0];
      collect32();
    end
    out_ready_w = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
